piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, parallel word width in bits (legal range 2..16).
REQ-002 Parameter MSB_FIRST, default 1; 1 = shift pi[WIDTH-1] first, 0 = shift pi[0] first.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 pi  input  WIDTH  parallel word to transmit.
REQ-006 pi_valid  input  1  pi holds a word to send.
REQ-007 pi_ready  output  1  block accepts pi this cycle.
REQ-008 so  output  1  serial line, idle-high.
REQ-009 busy  output  1  frame in progress (any state other than IDLE).
REQ-010 done  output  1  one-cycle pulse on the last cycle of each frame.

Function
REQ-011 Handshake: a word SHALL be accepted on a rising edge where pi_valid=1 and pi_ready=1; pi is captured into an internal shift register in that same edge.
REQ-012 pi_ready SHALL be 1 in IDLE and in STOP, 0 in every other state; pi_valid without pi_ready SHALL have no effect.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (only with the Configuration feature), STOP.
REQ-014 IDLE: so=1; on accept, next state START.
REQ-015 START: so=0 for exactly one cycle; next state DATA.
REQ-016 DATA: so = current bit of shift register, one bit per cycle, WIDTH cycles, order per MSB_FIRST; the bit counter counts 0..WIDTH-1 and leaves DATA after the WIDTH-1 count.
REQ-017 After DATA, next state SHALL be PARITY (feature on) or STOP (feature off).
REQ-018 STOP: so=1 for one cycle, done=1; next state START if a word is accepted in this cycle, else IDLE (back-to-back frames have no idle gap).
REQ-019 First start bit SHALL appear on so in the cycle after acceptance; frame length is WIDTH+2 cycles (WIDTH+3 with parity).
REQ-020 so, busy, done SHALL be registered outputs (no combinational path from pi/pi_valid).
REQ-021 Changes on pi after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-022 clear=1 SHALL force, at the next edge: state IDLE, so=1, busy=0, done=0, bit counter 0, shift register 0.
REQ-023 clear during a frame SHALL abort it without a done pulse; no word is accepted in a cycle where clear=1 (pi_ready=0 while clear=1).

Configuration
REQ-024 Macro PISO_TX_PARITY_EN: when defined, PARITY state is compiled in and drives so = XOR of the accepted data bits (even parity) for one cycle between DATA and STOP.
REQ-025 Without PISO_TX_PARITY_EN, no PARITY state, no parity logic; DATA goes directly to STOP.

Structure
REQ-026 Shared package piso_pkg SHALL hold the FSM state typedef, the state encodings, and the default WIDTH constant.
REQ-027 The bit counter SHALL be a sub-module piso_bitcnt (load/clear/enable inputs, terminal-count output, width $clog2(WIDTH)).

Verification (WIDTH=4 unless stated)
REQ-028 clear pulse mid-idle -> so=1, busy=0, pi_ready=1, done=0 next cycle.
REQ-029 Send 4'b1001, MSB_FIRST=1, parity off -> so = 0,1,0,0,1,1 then idle 1; done high on the final 1 only.
REQ-030 Send 4'b1011, MSB_FIRST=0, PISO_TX_PARITY_EN defined -> so = 0,1,1,0,1,1(parity),1(stop).
REQ-031 Words 4'b1010 then 4'b1110 with pi_valid held -> second start bit immediately after first stop, pi_ready high only in IDLE/STOP cycles, two done pulses 6 cycles apart.
REQ-032 Send 4'b1111, assert clear on third DATA cycle -> next cycle so=1, busy=0, no done pulse; subsequent 4'b0000 frame = 0,0,0,0,0,1.
REQ-033 pi changed from 4'b1001 to 4'b0110 one cycle after acceptance -> transmitted bits remain 1,0,0,1.

Source files
------------

// File: rtl/piso_pkg.sv
//==============================================================================
// Package  : piso_pkg
// Brief    : Shared definitions for the piso_tx serialiser: FSM state type,
//            state encodings and the default parallel word width.
// Ports    : none (package)
// Macro    : PISO_TX_PARITY_EN adds the PARITY state encoding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package piso_pkg;

    localparam int c_default_width = 4;
    localparam int c_state_w       = 3;

    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_idle   = 3'd0;
    localparam state_t c_start  = 3'd1;
    localparam state_t c_data   = 3'd2;
    localparam state_t c_stop   = 3'd3;
`ifdef PISO_TX_PARITY_EN
    localparam state_t c_parity = 3'd4;
`endif

endpackage : piso_pkg

`default_nettype wire

// File: rtl/piso_bitcnt.sv
//==============================================================================
// Module   : piso_bitcnt
// Brief    : Data-bit counter for piso_tx. Counts 0..WIDTH-1 and flags the
//            last count so the FSM knows when the final data bit is on the line.
// Ports    : clk     - clock
//            clear   - synchronous active-high reset (count -> 0)
//            i_load  - restart the count at 0
//            i_en    - advance the count by one
//            o_tc    - terminal count (count == WIDTH-1)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module piso_bitcnt #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int c_cw = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    logic [c_cw-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear || i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_tc = (r_count == c_last);

endmodule : piso_bitcnt

`default_nettype wire

// File: rtl/piso_tx.sv
//==============================================================================
// Module   : piso_tx
// Brief    : Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a
//            valid/ready handshake and sends a frame: start bit (0), WIDTH data
//            bits, optional even-parity bit, stop bit (1). Line idles high.
//            Back-to-back frames are possible: a word accepted in STOP starts
//            the next frame without an idle gap.
// Ports    : clk      - clock
//            clear    - synchronous active-high reset, aborts any frame
//            pi       - parallel word
//            pi_valid - pi holds a word to send
//            pi_ready - word accepted this cycle when pi_valid is also high
//            so       - serial line (registered, idle high)
//            busy     - frame in progress (registered)
//            done     - one-cycle pulse on the stop bit (registered)
// Macro    : PISO_TX_PARITY_EN - when defined, an even-parity bit is sent
//            between the last data bit and the stop bit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic             so,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_so;
    logic             r_busy;
    logic             r_done;
`ifdef PISO_TX_PARITY_EN
    logic             r_par;
`endif

    logic             w_accept;
    logic             w_tc;
    logic             w_out_bit;
    logic [WIDTH-1:0] w_shifted;

    // Ready only where a new frame may begin; never while clear is asserted.
    assign pi_ready = !clear && ((r_state == c_idle) || (r_state == c_stop));
    assign w_accept = pi_valid && pi_ready;

    // The bit on the line is always taken from the head of the shift register,
    // and the register moves toward that head after each emitted bit.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign w_out_bit = r_shreg[WIDTH-1];
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign w_out_bit = r_shreg[0];
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    piso_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk    (clk),
        .clear  (clear),
        .i_load (r_state == c_start),
        .i_en   ((r_state == c_data) && !w_tc),
        .o_tc   (w_tc)
    );

    // Outputs are registered alongside the state: each branch loads the value
    // the line must show during the state being entered.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= c_idle;
            r_shreg <= '0;
            r_so    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_state <= c_start;
                        r_so    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                c_start: begin
                    r_state <= c_data;
                    r_so    <= w_out_bit;
                    r_shreg <= w_shifted;
                end
                c_data: begin
                    if (w_tc) begin
`ifdef PISO_TX_PARITY_EN
                        r_state <= c_parity;
                        r_so    <= r_par;
`else
                        r_state <= c_stop;
                        r_so    <= 1'b1;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_so    <= w_out_bit;
                        r_shreg <= w_shifted;
                    end
                end
`ifdef PISO_TX_PARITY_EN
                c_parity: begin
                    r_state <= c_stop;
                    r_so    <= 1'b1;
                    r_done  <= 1'b1;
                end
`endif
                c_stop: begin
                    if (w_accept) begin
                        r_state <= c_start;
                        r_so    <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= c_idle;
                        r_so    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_so    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase

            // Acceptance only happens in IDLE/STOP, where the case above leaves
            // the shift register alone, so the capture never collides.
            if (w_accept) begin
                r_shreg <= pi;
`ifdef PISO_TX_PARITY_EN
                r_par   <= ^pi;
`endif
            end
        end
    end

    assign so   = r_so;
    assign busy = r_busy;
    assign done = r_done;

endmodule : piso_tx

`default_nettype wire

// File: tb/tb_piso_tx.sv
//==============================================================================
// Module   : tb_piso_tx
// Brief    : Directed self-checking bench for piso_tx. One MSB-first and one
//            LSB-first instance share clock and clear; expected line values
//            are written out by hand per cycle.
// Ports    : none
// Macro    : PISO_TX_PARITY_EN selects the parity-frame expectations.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_piso_tx;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] pi0, pi1;
    logic       pv0, pv1;
    logic       rdy0, rdy1;
    logic       so0, so1;
    logic       busy0, busy1;
    logic       done0, done1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk      (clk),
        .clear    (clear),
        .pi       (pi0),
        .pi_valid (pv0),
        .pi_ready (rdy0),
        .so       (so0),
        .busy     (busy0),
        .done     (done0)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk      (clk),
        .clear    (clear),
        .pi       (pi1),
        .pi_valid (pv1),
        .pi_ready (rdy1),
        .so       (so1),
        .busy     (busy1),
        .done     (done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected vectors are written in time order: the leftmost of n bits is
    // the first sampled cycle. One negedge is consumed per checked cycle.
    task automatic frame(input string tag, input bit sel, input int n,
                         input logic [15:0] eso, input logic [15:0] edone,
                         input logic [15:0] ebusy, input logic [15:0] erdy);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.so[%0d]",    tag, i), sel ? so1   : so0,   eso[n-1-i]);
            check($sformatf("%s.done[%0d]",  tag, i), sel ? done1 : done0, edone[n-1-i]);
            check($sformatf("%s.busy[%0d]",  tag, i), sel ? busy1 : busy0, ebusy[n-1-i]);
            check($sformatf("%s.ready[%0d]", tag, i), sel ? rdy1  : rdy0,  erdy[n-1-i]);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1;
        pi0 = 4'b0000; pv0 = 1'b0;
        pi1 = 4'b0000; pv1 = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst.so",    so0,   1'b1);
        check("rst.busy",  busy0, 1'b0);
        check("rst.done",  done0, 1'b0);
        check("rst.ready_in_clear", rdy0, 1'b0);
        check("rst.so_lsb", so1,  1'b1);
        clear = 1'b0;
        @(negedge clk);
        check("rst.ready", rdy0, 1'b1);

        // Clear pulse while idle
        clear = 1'b1;
        #1;
        check("idleclr.ready_in_clear", rdy0, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("idleclr.so",    so0,   1'b1);
        check("idleclr.busy",  busy0, 1'b0);
        check("idleclr.done",  done0, 1'b0);
        check("idleclr.ready", rdy0,  1'b1);
        @(negedge clk);

        // 1001 MSB first: start, 1,0,0,1, stop, idle
        pi0 = 4'b1001; pv0 = 1'b1;
        @(negedge clk);
        pv0 = 1'b0;
        frame("f1001", 1'b0, 7, 7'b0100111, 7'b0000010, 7'b1111110, 7'b0000011);

        // LSB first 1011 (and parity when compiled in)
        pi1 = 4'b1011; pv1 = 1'b1;
        @(negedge clk);
        pv1 = 1'b0;
`ifdef PISO_TX_PARITY_EN
        frame("l1011p", 1'b1, 8, 8'b01101111, 8'b00000010, 8'b11111110, 8'b00000011);
`else
        frame("l1011", 1'b1, 7, 7'b0110111, 7'b0000010, 7'b1111110, 7'b0000011);
`endif

        // LSB first 0110: parity bit is 0
        pi1 = 4'b0110; pv1 = 1'b1;
        @(negedge clk);
        pv1 = 1'b0;
`ifdef PISO_TX_PARITY_EN
        frame("l0110p", 1'b1, 8, 8'b00110011, 8'b00000010, 8'b11111110, 8'b00000011);
`else
        frame("l0110", 1'b1, 7, 7'b0011011, 7'b0000010, 7'b1111110, 7'b0000011);
`endif

        // Back-to-back 1010 then 1110 with pi_valid held
        pi0 = 4'b1010; pv0 = 1'b1;
        @(negedge clk);
        pi0 = 4'b1110;
        frame("b2b1", 1'b0, 6, 6'b010101, 6'b000001, 6'b111111, 6'b000001);
        pv0 = 1'b0;
        frame("b2b2", 1'b0, 7, 7'b0111011, 7'b0000010, 7'b1111110, 7'b0000011);

        // 1111 aborted by clear in the third data cycle
        pi0 = 4'b1111; pv0 = 1'b1;
        @(negedge clk);
        pv0 = 1'b0;
        frame("abort", 1'b0, 3, 3'b011, 3'b000, 3'b111, 3'b000);
        check("abort.so_d2", so0, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("abort.so",   so0,   1'b1);
        check("abort.busy", busy0, 1'b0);
        check("abort.done", done0, 1'b0);
        @(negedge clk);
        check("abort.done_after", done0, 1'b0);
        check("abort.ready",      rdy0,  1'b1);
        pi0 = 4'b0000; pv0 = 1'b1;
        @(negedge clk);
        pv0 = 1'b0;
        frame("f0000", 1'b0, 7, 7'b0000011, 7'b0000010, 7'b1111110, 7'b0000011);

        // pi changes after acceptance must not disturb the frame
        pi0 = 4'b1001; pv0 = 1'b1;
        @(negedge clk);
        pv0 = 1'b0;
        pi0 = 4'b0110;
        frame("hold", 1'b0, 7, 7'b0100111, 7'b0000010, 7'b1111110, 7'b0000011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_piso_tx

`default_nettype wire
